// File: rtl/mem_wb_stage.sv
// mem_wb_stage
//   MEM/WB pipeline register plus writeback-data alignment. Registers the
//   memory-stage result and control fields. Load data returned by the
//   synchronous data SRAM one cycle after the access is then aligned and
//   sign/zero-extended.
//
// Optional feature macro: MEM_WB_LOAD_HOLD_EN
//   Defined     : a hold buffer captures DM_out on the first stalled edge.
//                 Load data then stays correct across stalls of any length.
//   Not defined : raw load data is always DM_out. The memory stage must
//                 keep the SRAM idle during stalls so DM_out stays stable.
//
// Ports
//   clk, rst                  clock and synchronous active-high reset
//   stall, flush              hold all registers / insert a bubble
//   MEM_rd_data               non-load result from the memory stage
//   MEM_ALU_off               byte offset of the load address
//   MEM_funct3                load type
//   MEM_WB_data_sel           1 = writeback takes load data
//   MEM_WB_rd_addr            destination register
//   MEM_WB_reg_file_write     integer register-file write enable
//   MEM_WB_reg_file_FP_write  FP register-file write enable
//   DM_out                    SRAM read data, valid the cycle after the access
//   WB_rd_addr                registered destination register
//   WB_reg_file_write         registered integer write enable
//   WB_reg_file_FP_write      registered FP write enable
//   WB_rd_data                final writeback/forwarding data
//   WB_valid                  stage holds a live instruction

`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module mem_wb_stage #(
  parameter int DATA_WIDTH = `DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] MEM_rd_data,
  input  logic [1:0]            MEM_ALU_off,
  input  logic [2:0]            MEM_funct3,
  input  logic                  MEM_WB_data_sel,
  input  logic [4:0]            MEM_WB_rd_addr,
  input  logic                  MEM_WB_reg_file_write,
  input  logic                  MEM_WB_reg_file_FP_write,
  input  logic [DATA_WIDTH-1:0] DM_out,
  output logic [4:0]            WB_rd_addr,
  output logic                  WB_reg_file_write,
  output logic                  WB_reg_file_FP_write,
  output logic [DATA_WIDTH-1:0] WB_rd_data,
  output logic                  WB_valid
);

  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic [1:0]            off_q, off_d;
  logic [2:0]            funct3_q, funct3_d;
  logic                  data_sel_q, data_sel_d;
  logic [4:0]            rd_addr_q, rd_addr_d;
  logic                  we_q, we_d;
  logic                  fp_we_q, fp_we_d;
  logic                  valid_q, valid_d;

  logic [DATA_WIDTH-1:0] raw;
  logic [7:0]            load_byte;
  logic [15:0]           load_half;
  logic [DATA_WIDTH-1:0] load_data;

  // Stall wins over flush; flush only clears the control fields and
  // leaves the data fields as they were.
  always_comb begin
    rd_data_d  = rd_data_q;
    off_d      = off_q;
    funct3_d   = funct3_q;
    data_sel_d = data_sel_q;
    rd_addr_d  = rd_addr_q;
    we_d       = we_q;
    fp_we_d    = fp_we_q;
    valid_d    = valid_q;
    if (!stall) begin
      if (flush) begin
        we_d    = 1'b0;
        fp_we_d = 1'b0;
        valid_d = 1'b0;
      end else begin
        rd_data_d  = MEM_rd_data;
        off_d      = MEM_ALU_off;
        funct3_d   = MEM_funct3;
        data_sel_d = MEM_WB_data_sel;
        rd_addr_d  = MEM_WB_rd_addr;
        we_d       = MEM_WB_reg_file_write;
        fp_we_d    = MEM_WB_reg_file_FP_write;
        valid_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q  <= '0;
      off_q      <= '0;
      funct3_q   <= '0;
      data_sel_q <= 1'b0;
      rd_addr_q  <= '0;
      we_q       <= 1'b0;
      fp_we_q    <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      off_q      <= off_d;
      funct3_q   <= funct3_d;
      data_sel_q <= data_sel_d;
      rd_addr_q  <= rd_addr_d;
      we_q       <= we_d;
      fp_we_q    <= fp_we_d;
      valid_q    <= valid_d;
    end
  end

`ifdef MEM_WB_LOAD_HOLD_EN
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic                  hold_valid_q, hold_valid_d;

  // DM_out is only guaranteed during the first WB cycle, so latch it on
  // the first stalled edge and keep it until the stall releases.
  always_comb begin
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    if (stall) begin
      if (!hold_valid_q) begin
        hold_d       = DM_out;
        hold_valid_d = 1'b1;
      end
    end else begin
      hold_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
    end else begin
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
    end
  end

  assign raw = hold_valid_q ? hold_q : DM_out;
`else
  assign raw = DM_out;
`endif

  // Halfwords ignore off[0]; misaligned accesses are not trapped here.
  assign load_byte = raw[{off_q, 3'b000} +: 8];
  assign load_half = raw[{off_q[1], 4'b0000} +: 16];

  always_comb begin
    load_data = '0;
    case (funct3_q)
      3'b000:  load_data = {{(DATA_WIDTH-8){load_byte[7]}}, load_byte};
      3'b001:  load_data = {{(DATA_WIDTH-16){load_half[15]}}, load_half};
      3'b010:  load_data = raw;
      3'b100:  load_data = {{(DATA_WIDTH-8){1'b0}}, load_byte};
      3'b101:  load_data = {{(DATA_WIDTH-16){1'b0}}, load_half};
      default: load_data = '0;
    endcase
  end

  assign WB_rd_data           = data_sel_q ? load_data : rd_data_q;
  assign WB_rd_addr           = rd_addr_q;
  assign WB_reg_file_write    = we_q;
  assign WB_reg_file_FP_write = fp_we_q;
  assign WB_valid             = valid_q;

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

MEM/WB pipeline register and writeback-data stage, sitting directly downstream of the memory stage and feeding the integer/FP register files and the forwarding unit. It registers memory-stage results and control, then aligns and extends load data returned by the synchronous data SRAM one cycle after the access. It supports pipeline stall and flush, and can optionally preserve SRAM read data across multi-cycle stalls.

## Interface
- DATA_WIDTH, 32, datapath width (from `` `DATA_WIDTH``)
- clk  input  1  system clock, rising edge
- rst  input  1  reset, synchronous, active-high
- stall  input  1  hold all stage registers
- flush  input  1  insert bubble into the stage
- MEM_rd_data  input  32  non-load result from the memory stage (ALU/PC/FP/CSR already muxed)
- MEM_ALU_off  input  2  byte offset of the load address (ALU result [1:0])
- MEM_funct3  input  3  load type
- MEM_WB_data_sel  input  1  1 = writeback takes load data, 0 = MEM_rd_data
- MEM_WB_rd_addr  input  5  destination register
- MEM_WB_reg_file_write  input  1  integer RF write enable
- MEM_WB_reg_file_FP_write  input  1  FP RF write enable
- DM_out  input  32  SRAM read data, valid the cycle after the access
- WB_rd_addr  output  5  registered destination register
- WB_reg_file_write  output  1  integer RF write enable
- WB_reg_file_FP_write  output  1  FP RF write enable
- WB_rd_data  output  32  final writeback/forwarding data
- WB_valid  output  1  stage holds a live instruction

## Operation
- Register update priority on each clk edge: rst, then stall (hold), then flush, then capture.
- rst clears every register; all outputs read 0 and hold_valid is 0.
- While stall is asserted, every register holds, and flush is ignored.
- On flush without stall: WB_valid and both write enables become 0. Data fields are don't-care and are held.
- On capture: all MEM_* inputs are registered, and WB_valid becomes 1.
- Load alignment is combinational from the registered fields:
  - raw = hold_q if hold_valid, else DM_out.
  - Byte/halfword source: LB/LBU use raw[{off,3'b0} +: 8]; LH/LHU use raw[{off[1],4'b0} +: 16]; LW ignores off.
  - funct3 000 LB: sign-extended from the byte's bit 7.
  - 001 LH: sign-extended from the halfword's bit 15.
  - 010 LW: raw.
  - 100 LBU and 101 LHU: zero-extended.
  - Any other funct3: 0.
- WB_rd_data = WB_data_sel_q ? load_data : rd_data_q.
- Misaligned LH at off=3 and misaligned LW are not trapped. off[0] is ignored for halfwords.

## Timing
- Latency: MEM inputs appear on the WB outputs 1 cycle after a capture edge.
- DM_out must correspond to the access issued in the MEM cycle that was captured. It is consumed in the first WB cycle.
- Write enables are registered outputs, with no combinational path from the inputs.
- WB_rd_data has a combinational path from DM_out (when hold_valid=0) and no path from any MEM_* input.
- Hold buffer (under the macro below):
  - On an edge with stall=1 and hold_valid=0: hold_q <= DM_out and hold_valid <= 1.
  - On an edge with stall=0: hold_valid <= 0.
  - When a stall starts and ends in the same window (single-cycle stall), the data comes from hold_q during the second cycle.
- Reset mid-stall clears hold_valid immediately at that edge.

## Configuration
- MEM_WB_LOAD_HOLD_EN defined:
  - hold_q/hold_valid are implemented.
  - Load data is correct for stalls of any length, even if the SRAM output changes during the stall.
- Not defined:
  - raw = DM_out always, and no hold registers exist.
  - The memory stage must keep the SRAM chip-select inactive during stalls so that DM_out is stable.

## Test plan
- LB: off=2, DM_out=0x1280_3456, WB_data_sel=1 -> WB_rd_data=0xFFFF_FF80 one cycle after capture. Same case with LBU -> 0x0000_0080.
- LH and LHU: off=2, DM_out=0x8001_1234 -> LH gives 0xFFFF_8001 and LHU gives 0x0000_8001. LW with off=3 -> 0x8001_1234.
- Non-load: MEM_rd_data=0xDEAD_BEEF, data_sel=0, rd=5, write=1 -> next cycle WB_rd_data=0xDEAD_BEEF, WB_rd_addr=5, WB_reg_file_write=1, WB_valid=1.
- Stall with MEM_WB_LOAD_HOLD_EN:
  - Setup: LW captured with DM_out=0x1111_2222, then stall held 3 cycles while DM_out changes to 0xFFFF_FFFF.
  - Required: WB_rd_data stays 0x1111_2222 throughout, and the outputs advance on the first non-stall edge.
- Flush alone -> next cycle WB_valid=0 and both write enables 0. Flush with stall -> outputs unchanged.
- rst asserted during a stalled load -> next cycle all outputs 0 and hold_valid=0. A capture after rst behaves normally.
